// File: rtl/array_heap_pkg.sv
// Shared types for the array heap: action codes, FSM states and scan compare modes.
package array_heap_pkg;

  localparam int unsigned ACTION_BITS = 8;

  typedef logic [ACTION_BITS-1:0] action_t;

  localparam action_t ACT_CLEAR   = 8'd1;
  localparam action_t ACT_WRITE   = 8'd2;
  localparam action_t ACT_READ    = 8'd3;
  localparam action_t ACT_SIZE    = 8'd4;
  localparam action_t ACT_PUSH    = 8'd5;
  localparam action_t ACT_POP     = 8'd6;
  localparam action_t ACT_LESS    = 8'd7;
  localparam action_t ACT_EQUAL   = 8'd8;
  localparam action_t ACT_GREATER = 8'd9;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CMP_LESS    = 2'd0,
    CMP_EQUAL   = 2'd1,
    CMP_GREATER = 2'd2
  } cmp_mode_t;

  function automatic logic is_scan_action(input action_t code);
    return (code == ACT_LESS) || (code == ACT_EQUAL) || (code == ACT_GREATER);
  endfunction

  function automatic cmp_mode_t cmp_mode_of(input action_t code);
    cmp_mode_t mode;
    mode = CMP_LESS;
    case (code)
      ACT_EQUAL:   mode = CMP_EQUAL;
      ACT_GREATER: mode = CMP_GREATER;
      default:     mode = CMP_LESS;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/array_heap_scan.sv
// Compare-and-count unit: accumulates how many scanned elements satisfy the selected
// unsigned comparison against the operand. count_c already includes the current element.
module array_heap_scan
  import array_heap_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 16,
  parameter int unsigned COUNT_BITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_BITS-1:0]  element,
  input  logic [DATA_BITS-1:0]  operand,
  input  cmp_mode_t             mode,
  input  logic                  enable,
  input  logic                  clear,
  output logic [COUNT_BITS-1:0] count_c
);

  logic [COUNT_BITS-1:0] count_q;
  logic                  hit;

  always_comb begin
    hit = 1'b0;
    case (mode)
      CMP_LESS:    hit = element < operand;
      CMP_EQUAL:   hit = element == operand;
      CMP_GREATER: hit = element > operand;
      default:     hit = 1'b0;
    endcase
  end

  assign count_c = count_q + COUNT_BITS'(hit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_c;
    end
  end

endmodule

// File: rtl/array_heap.sv
// Multi-array heap memory with start/done handshake: element, stack and scan-count actions.
// Define ARRAY_HEAP_CHECK_EN to flag bad reads, push-when-full, pop-when-empty and unknown codes.
module array_heap
  import array_heap_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 8,
  parameter int unsigned INDEX_BITS   = 3,
  parameter int unsigned DATA_BITS    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ACTION_BITS-1:0]  action,
  input  logic [ADDRESS_BITS-1:0] array,
  input  logic [INDEX_BITS-1:0]   index,
  input  logic [DATA_BITS-1:0]    in,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_BITS-1:0]    out,
  output logic                    error
);

  localparam int unsigned ARRAYS       = 1 << ADDRESS_BITS;
  localparam int unsigned ARRAY_LENGTH = 1 << INDEX_BITS;
  localparam int unsigned SIZE_W       = INDEX_BITS + 1;

`ifdef ARRAY_HEAP_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  state_t state, state_next;

  logic [DATA_BITS-1:0]  mem   [ARRAYS][ARRAY_LENGTH];
  logic [SIZE_W-1:0]     sizes [ARRAYS];

  logic [SIZE_W-1:0]     cur_size;
  logic                  accept_c, scan_req_c, full_c, empty_c;
  logic [INDEX_BITS-1:0] top_idx_c, push_idx_c;

  logic [ADDRESS_BITS-1:0] scan_array;
  logic [DATA_BITS-1:0]    scan_operand;
  cmp_mode_t               scan_mode;
  logic [INDEX_BITS-1:0]   scan_idx, scan_last;
  logic                    scan_at_last_c;
  logic                    scan_en_c, scan_clear_c, scan_finish_c;
  logic [SIZE_W-1:0]       count_c;

  logic [DATA_BITS-1:0]  res_out;
  logic [SIZE_W-1:0]     res_size;
  logic                  res_err, size_we, mem_we;
  logic [INDEX_BITS-1:0] mem_idx;

  assign cur_size       = sizes[array];
  assign accept_c       = start && (state == IDLE);
  assign scan_req_c     = is_scan_action(action);
  assign full_c         = cur_size == SIZE_W'(ARRAY_LENGTH);
  assign empty_c        = cur_size == '0;
  assign top_idx_c      = INDEX_BITS'(cur_size - SIZE_W'(1));
  assign push_idx_c     = INDEX_BITS'(cur_size);
  assign scan_at_last_c = scan_idx == scan_last;

  // Result of a single-cycle action (and of a scan on an empty array) for the addressed array.
  always_comb begin
    res_out  = out;
    res_size = cur_size;
    res_err  = 1'b0;
    size_we  = 1'b0;
    mem_we   = 1'b0;
    mem_idx  = index;
    case (action)
      ACT_CLEAR: begin
        size_we  = 1'b1;
        res_size = '0;
        res_out  = '0;
      end
      ACT_WRITE: begin
        mem_we  = 1'b1;
        res_out = in;
        if ({1'b0, index} >= cur_size) begin
          size_we  = 1'b1;
          res_size = {1'b0, index} + SIZE_W'(1);
        end
      end
      ACT_READ: begin
        if (CHECK_EN && ({1'b0, index} >= cur_size)) begin
          res_err = 1'b1;
          res_out = '0;
        end else begin
          res_out = mem[array][index];
        end
      end
      ACT_SIZE: res_out = DATA_BITS'(cur_size);
      ACT_PUSH: begin
        if (full_c) begin
          res_err = CHECK_EN;
          res_out = CHECK_EN ? '0 : DATA_BITS'(cur_size);
        end else begin
          mem_we   = 1'b1;
          mem_idx  = push_idx_c;
          size_we  = 1'b1;
          res_size = cur_size + SIZE_W'(1);
          res_out  = DATA_BITS'(res_size);
        end
      end
      ACT_POP: begin
        if (empty_c) begin
          res_err = CHECK_EN;
          res_out = '0;
        end else begin
          size_we  = 1'b1;
          res_size = cur_size - SIZE_W'(1);
          res_out  = mem[array][top_idx_c];
        end
      end
      ACT_LESS, ACT_EQUAL, ACT_GREATER: res_out = '0;
      default: begin
        res_err = CHECK_EN;
        if (CHECK_EN) res_out = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c && scan_req_c && !empty_c) state_next = SCAN;
      SCAN:    if (scan_at_last_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    scan_en_c     = 1'b0;
    scan_clear_c  = 1'b0;
    scan_finish_c = 1'b0;
    case (state)
      IDLE: scan_clear_c = accept_c && scan_req_c;
      SCAN: begin
        scan_en_c     = 1'b1;
        scan_finish_c = scan_at_last_c;
      end
      default: ;
    endcase
  end

  array_heap_scan #(
    .DATA_BITS (DATA_BITS),
    .COUNT_BITS(SIZE_W)
  ) u_scan (
    .clock  (clock),
    .reset  (reset),
    .element(mem[scan_array][scan_idx]),
    .operand(scan_operand),
    .mode   (scan_mode),
    .enable (scan_en_c),
    .clear  (scan_clear_c),
    .count_c(count_c)
  );

  // Element storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (accept_c && mem_we) mem[array][mem_idx] <= in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      out          <= '0;
      error        <= 1'b0;
      scan_array   <= '0;
      scan_operand <= '0;
      scan_mode    <= CMP_LESS;
      scan_idx     <= '0;
      scan_last    <= '0;
      for (int i = 0; i < ARRAYS; i++) sizes[i] <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (accept_c) begin
        if (scan_req_c && !empty_c) begin
          busy         <= 1'b1;
          scan_array   <= array;
          scan_operand <= in;
          scan_mode    <= cmp_mode_of(action);
          scan_idx     <= '0;
          scan_last    <= top_idx_c;
        end else begin
          done  <= 1'b1;
          out   <= res_out;
          error <= res_err;
          if (size_we) sizes[array] <= res_size;
        end
      end else if (scan_finish_c) begin
        busy <= 1'b0;
        done <= 1'b1;
        out  <= DATA_BITS'(count_c);
      end else if (scan_en_c) begin
        scan_idx <= scan_idx + INDEX_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_array_heap.sv
// Scoreboard bench for array_heap; expectations come from a behavioural model of the heap.
// Honours ARRAY_HEAP_CHECK_EN to pick the checked or unchecked corner-case behaviour.
module tb_array_heap;

  localparam int AB = 2;
  localparam int IB = 2;
  localparam int DB = 12;
  localparam int NARR = 1 << AB;
  localparam int LEN  = 1 << IB;

`ifdef ARRAY_HEAP_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic          clock, reset, start;
  logic [7:0]    action;
  logic [AB-1:0] arr;
  logic [IB-1:0] idx;
  logic [DB-1:0] din;
  logic          busy, done, error;
  logic [DB-1:0] dout;

  array_heap #(.ADDRESS_BITS(AB), .INDEX_BITS(IB), .DATA_BITS(DB)) dut (
    .clock(clock), .reset(reset), .start(start), .action(action), .array(arr),
    .index(idx), .in(din), .busy(busy), .done(done), .out(dout), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int act;
    int out;
    int err;
    int issue;
    int done_cyc;
    bit scan;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // behavioural model state
  int m_mem  [NARR][LEN];
  int m_size [NARR];
  int m_last = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int a = 0; a < NARR; a++) m_size[a] = 0;
    m_last = 0;
  endfunction

  function automatic void model(input int act, input int a, input int i, input int d,
                                output int o, output int e, output int lat);
    int sz;
    sz  = m_size[a];
    e   = 0;
    lat = 1;
    o   = m_last;
    case (act)
      1: begin m_size[a] = 0; o = 0; end
      2: begin m_mem[a][i] = d; if (i >= sz) m_size[a] = i + 1; o = d; end
      3: if (EN && i >= sz) begin e = 1; o = 0; end else o = m_mem[a][i];
      4: o = sz;
      5: if (sz == LEN) begin e = EN ? 1 : 0; o = EN ? 0 : sz; end
         else begin m_mem[a][sz] = d; m_size[a] = sz + 1; o = sz + 1; end
      6: if (sz == 0) begin e = EN ? 1 : 0; o = 0; end
         else begin m_size[a] = sz - 1; o = m_mem[a][sz - 1]; end
      7, 8, 9: begin
        o = 0;
        for (int k = 0; k < sz; k++) begin
          if (act == 7 && m_mem[a][k] <  d) o++;
          if (act == 8 && m_mem[a][k] == d) o++;
          if (act == 9 && m_mem[a][k] >  d) o++;
        end
        lat = 1 + sz;
      end
      default: if (EN) begin e = 1; o = 0; end
    endcase
    m_last = o;
  endfunction

  // Drive one start pulse; returns one cycle later, 1ns after the sampling edge.
  task automatic issue(input int act, input int a, input int i, input int d);
    exp_t x;
    int o, e, lat;
    model(act, a, i, d, o, e, lat);
    x.act = act; x.out = o; x.err = e; x.issue = cyc; x.done_cyc = cyc + lat; x.scan = lat > 1;
    sb.push_back(x);
    start = 1'b1; action = 8'(act); arr = AB'(a); idx = IB'(i); din = DB'(d);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clock); #1;
      t++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic op(input int act, input int a, input int i, input int d);
    issue(act, a, i, d);
    wait_idle();
  endtask

  // Monitor: checks busy every cycle and every done pulse against the scoreboard head.
  always @(negedge clock) begin
    exp_t x;
    int eb;
    if (!reset) begin
      eb = 0;
      if (sb.size() > 0 && sb[0].scan && cyc > sb[0].issue && cyc < sb[0].done_cyc) eb = 1;
      chk("busy", int'(busy), eb);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          x = sb.pop_front();
          chk($sformatf("out_act%0d", x.act), int'(dout), x.out);
          chk($sformatf("error_act%0d", x.act), int'(error), x.err);
          chk($sformatf("latency_act%0d", x.act), cyc, x.done_cyc);
        end
      end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
        x = sb.pop_front();
        chk($sformatf("missing_done_act%0d", x.act), 0, 1);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; action = '0; arr = '0; idx = '0; din = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_out", int'(dout), 0);
    chk("reset_error", int'(error), 0);

    op(4, 3, 0, 0);
    // give every element a known value, then empty every array
    for (int a = 0; a < NARR; a++)
      for (int i = 0; i < LEN; i++) op(2, a, i, $urandom_range(0, 4095));
    for (int a = 0; a < NARR; a++) op(1, a, 0, 0);
    for (int a = 0; a < NARR; a++) op(4, a, 0, 0);

    // stack fill and overflow
    op(5, 1, 0, 5); op(5, 1, 0, 9); op(5, 1, 0, 2); op(5, 1, 0, 9);
    op(4, 1, 0, 0);
    op(5, 1, 0, 7);
    op(4, 1, 0, 0);

    // scans
    op(9, 1, 0, 4); op(8, 1, 0, 9); op(7, 1, 0, 5);

    // start pulses while busy are ignored
    issue(9, 1, 0, 4);
    start = 1'b1; action = 8'd1; arr = 2'd1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_idle();
    op(4, 1, 0, 0);

    // start in the done cycle of a scan is accepted
    issue(8, 1, 0, 9);
    repeat (4) @(posedge clock);
    #1 issue(4, 1, 0, 0);
    wait_idle();

    // pops and underflow
    for (int k = 0; k < 5; k++) op(6, 1, 0, 0);
    op(4, 1, 0, 0);
    op(9, 1, 0, 0);

    // write extends size, reads in and out of range
    op(2, 2, 3, 7); op(4, 2, 0, 0); op(3, 2, 3, 0);
    op(3, 0, 1, 0);
    op(0, 1, 0, 0); op(200, 2, 0, 0);

    // reset in the middle of a scan
    op(5, 3, 0, 1); op(5, 3, 0, 2); op(5, 3, 0, 3); op(5, 3, 0, 4);
    issue(9, 3, 0, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    sb.delete();
    model_reset();
    #1;
    chk("midscan_reset_busy", int'(busy), 0);
    chk("midscan_reset_done", int'(done), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    for (int a = 0; a < NARR; a++) op(4, a, 0, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int act, d;
      act = $urandom_range(0, 10);
      if (act == 1 && $urandom_range(0, 2) != 0) act = 5;
      d = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4095) : $urandom_range(0, 7);
      op(act, $urandom_range(0, NARR - 1), $urandom_range(0, LEN - 1), d);
    end

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
